// File: rtl/posit_decode.sv
// posit_decode: sequential posit unpacker.
// Splits an N-bit posit into sign, regime k, exponent and fraction. The
// regime run is counted one bit per cycle behind a start/done handshake.
// The scale/mantissa/sign results feed the multiplier datapath.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high (aborts any decode, clears outputs)
//   start      begin a decode; only sampled while idle
//   posit_in   posit word, captured on the accepted start edge
//   busy       high whenever the decoder is not idle
//   done       one-cycle pulse; result outputs are valid from this cycle on
//   sign_out   posit sign bit
//   k_out      signed regime value
//   exp_out    exponent field (bits cut off by a long regime read as 0)
//   scale_out  signed k*2^ES + exp_out
//   mant_out   {1, fraction, zero pad}, hidden bit at bit N-1
//   is_zero    input was zero
//   is_nar     input was NaR (1 followed by N-1 zeros)
module posit_decode #(
  parameter int N  = 32,
  parameter int ES = 3,
  parameter int KW = 6,
  parameter int SW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  posit_in,
  output logic          busy,
  output logic          done,
  output logic          sign_out,
  output logic [KW-1:0] k_out,
  output logic [ES-1:0] exp_out,
  output logic [SW-1:0] scale_out,
  output logic [N-1:0]  mant_out,
  output logic          is_zero,
  output logic          is_nar
);

  localparam int RW = $clog2(N);       // run counter holds 0..N-1
  localparam int FW = N - 1 - ES;      // fraction bits below the exponent
  localparam logic [RW-1:0] RUN_MAX = RW'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EXTRACT, FIN} state_t;

  state_t         state_reg, state_next;
  logic           sign_reg;
  logic [KW-1:0]  k_reg;
  logic [ES-1:0]  exp_reg;
  logic [SW-1:0]  scale_reg;
  logic [N-1:0]   mant_reg;
  logic           is_zero_reg, is_nar_reg;
  logic [N-2:0]   w_reg;
  logic           lead_reg;
  logic [RW-1:0]  run_reg;

  // Input classification. Only the low N-1 bits of |posit_in| matter because
  // the regime starts below the sign; the low bits of a two's-complement
  // negation depend only on the low bits of the operand.
  logic           in_zero, in_nar;
  logic [N-2:0]   abs_low;

  assign in_zero = (posit_in == '0);
  assign in_nar  = (posit_in == {1'b1, {(N-1){1'b0}}});
  assign abs_low = posit_in[N-1] ? ((N-1)'(0) - posit_in[N-2:0]) : posit_in[N-2:0];

  // Regime run continues while the next bit matches the leading regime bit.
  logic scan_more;
  assign scan_more = (w_reg[N-2] == lead_reg) && (run_reg < RUN_MAX);

  // Field extraction: drop the terminator unless the run filled the word.
  // Zero fill during the scan makes truncated exponent bits read as 0.
  logic [N-2:0]           w_ext;
  logic [KW-1:0]          k_calc;
  logic signed [SW-1:0]   k_wide;
  logic [SW-1:0]          scale_calc;

  assign w_ext      = (run_reg < RUN_MAX) ? (w_reg << 1) : w_reg;
  assign k_calc     = lead_reg ? (KW'(run_reg) - KW'(1)) : (KW'(0) - KW'(run_reg));
  assign k_wide     = SW'($signed(k_calc));
  assign scale_calc = SW'(k_wide <<< ES) | SW'(w_ext[N-2 -: ES]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (in_zero || in_nar) ? FIN : SCAN;
      SCAN:    if (!scan_more) state_next = EXTRACT;
      EXTRACT: state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == FIN);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg    <= 1'b0;
      k_reg       <= '0;
      exp_reg     <= '0;
      scale_reg   <= '0;
      mant_reg    <= '0;
      is_zero_reg <= 1'b0;
      is_nar_reg  <= 1'b0;
      w_reg       <= '0;
      lead_reg    <= 1'b0;
      run_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            // NaR reports a clear sign; every other result field restarts at 0.
            sign_reg    <= posit_in[N-1] & ~in_nar;
            k_reg       <= '0;
            exp_reg     <= '0;
            scale_reg   <= '0;
            mant_reg    <= '0;
            is_zero_reg <= in_zero;
            is_nar_reg  <= in_nar;
            w_reg       <= abs_low;
            lead_reg    <= abs_low[N-2];
            run_reg     <= '0;
          end
        end
        SCAN: begin
          if (scan_more) begin
            run_reg <= run_reg + RW'(1);
            w_reg   <= w_reg << 1;
          end
        end
        EXTRACT: begin
          k_reg     <= k_calc;
          exp_reg   <= w_ext[N-2 -: ES];
          scale_reg <= scale_calc;
          mant_reg  <= {1'b1, w_ext[FW-1:0], {ES{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  assign sign_out  = sign_reg;
  assign k_out     = k_reg;
  assign exp_out   = exp_reg;
  assign scale_out = scale_reg;
  assign mant_out  = mant_reg;
  assign is_zero   = is_zero_reg;
  assign is_nar    = is_nar_reg;

endmodule

// File: tb/tb_posit_decode.sv
// Testbench for posit_decode (N=32, ES=3). Stimulus pushes the expected
// result into a scoreboard queue; an independent monitor pops and compares
// every time the decoder pulses done.
module tb_posit_decode;

  localparam int N  = 32;
  localparam int ES = 3;
  localparam int KW = 6;
  localparam int SW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  posit_in;
  logic          busy, done, sign_out, is_zero, is_nar;
  logic [KW-1:0] k_out;
  logic [ES-1:0] exp_out;
  logic [SW-1:0] scale_out;
  logic [N-1:0]  mant_out;

  posit_decode #(.N(N), .ES(ES), .KW(KW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .posit_in(posit_in),
    .busy(busy), .done(done), .sign_out(sign_out), .k_out(k_out),
    .exp_out(exp_out), .scale_out(scale_out), .mant_out(mant_out),
    .is_zero(is_zero), .is_nar(is_nar)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] word;
    logic        sign;
    int          k;
    int          ex;
    int          scale;
    logic [31:0] mant;
    logic        zero;
    logic        nar;
    int          lat;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Reference decode straight from the posit definition: count the regime
  // run in |p|, then shift the consumed bits (sign, run, terminator) off the
  // top and read exponent and fraction from what is left.
  function automatic exp_t model(input logic [31:0] p);
    exp_t e;
    logic [31:0] a;
    logic [63:0] sh;
    logic [31:0] rem, frac;
    int m, used;
    bit lead, going;
    e.word = p; e.sign = 0; e.k = 0; e.ex = 0; e.scale = 0; e.mant = 0;
    e.zero = (p == 32'h0); e.nar = (p == 32'h8000_0000); e.lat = 1; e.due = 0;
    if (!(e.zero || e.nar)) begin
      e.sign = p[31];
      a = p[31] ? -p : p;
      lead = a[30];
      m = 0; going = 1;
      for (int i = 30; i >= 0; i--) begin
        if (going && a[i] == lead) m++;
        else going = 0;
      end
      used = 1 + m + ((m < 31) ? 1 : 0);
      sh = {32'h0, a} << used;
      rem = sh[31:0];
      e.ex = int'(rem[31:29]);
      frac = rem << ES;
      e.mant = 32'h8000_0000 | (frac >> 1);
      e.k = lead ? m - 1 : -m;
      e.scale = e.k * (1 << ES) + e.ex;
      e.lat = m + 3;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("latency", cyc, e.due);
        chk("sign", sign_out, e.sign);
        chk("k", int'($signed(k_out)), e.k);
        chk("exp", exp_out, e.ex);
        chk("scale", int'($signed(scale_out)), e.scale);
        chk("mant", mant_out, e.mant);
        chk("is_zero", is_zero, e.zero);
        chk("is_nar", is_nar, e.nar);
        $display("[TB] decode %08h -> s=%0d k=%0d e=%0d sc=%0d m=%08h z=%0d n=%0d", e.word,
                 sign_out, $signed(k_out), exp_out, $signed(scale_out), mant_out, is_zero, is_nar);
      end
    end
  end

  // Drive start from a negedge; returns 1 ns after the sampling edge.
  task automatic launch(input logic [31:0] p, input bit expect_it);
    exp_t e;
    e = model(p);
    posit_in = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.due = cyc + e.lat - 1;
    if (expect_it) begin
      sb_q.push_back(e);
      last_exp = e;
      // Accepted start clears old results (sign takes the new value).
      chk("start_clear_mant", mant_out, 0);
      chk("start_sign", sign_out, e.sign);
      chk("start_busy", busy, 1);
    end
  endtask

  // Wait (bounded) for done, then step into the following idle cycle.
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic decode(input logic [31:0] p);
    launch(p, 1);
    wait_done();
  endtask

  logic [31:0] directed [8] = '{32'h4000_0000, 32'h4800_0000, 32'h4010_0000, 32'hC000_0000,
                                32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};

  initial begin
    rst = 1'b1; start = 1'b0; posit_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outputs", {sign_out, k_out, exp_out, scale_out, mant_out, is_zero, is_nar}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner words, issued back-to-back.
    foreach (directed[i]) decode(directed[i]);

    // Results hold while idle.
    repeat (3) @(negedge clk);
    chk("hold_k", int'($signed(k_out)), last_exp.k);
    chk("hold_scale", int'($signed(scale_out)), last_exp.scale);
    chk("hold_mant", mant_out, last_exp.mant);

    // start and posit_in changes while busy are ignored.
    launch(32'h0000_0001, 1);
    repeat (4) @(negedge clk);
    posit_in = 32'h4000_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; posit_in = 32'hFFFF_FFFF;
    wait_done();

    // Reset mid-scan aborts with no done and clears everything.
    launch(32'h7FFF_FFFF, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_outputs", {sign_out, k_out, exp_out, scale_out, mant_out, is_zero, is_nar}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done_pending", sb_q.size(), 0);

    // Randomized words biased toward long regime runs of either polarity.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: r = r >> $urandom_range(0, 31);
        2: r = ~(r >> $urandom_range(0, 31));
        default: r = (32'h1 << $urandom_range(0, 31)) ^ {31'h0, r[0]};
      endcase
      decode(r);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
